// File: rtl/piece_fall_ctl.sv
// Falling-piece controller for a 1x1 block stacking game on a GRID_W x GRID_H board.
// Optional build macro: PIECE_FALL_CTL_HARD_DROP_EN (down edge drops the piece straight to its landing row).
module piece_fall_ctl #(
    parameter int GRID_W   = 10,
    parameter int GRID_H   = 20,
    parameter int CELL     = 35,
    parameter int X0       = 100,
    parameter int Y0       = 20,
    parameter int FALL_DIV = 1048576
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        button_left,
    input  logic        button_right,
    input  logic        button_down,
    input  logic        button_rotate,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        active,
    output logic        lock_pulse,
    output logic        clear_pulse,
    output logic [15:0] score,
    output logic        game_over
);

    localparam int CW   = $clog2(GRID_W);
    localparam int RW   = $clog2(GRID_H);
    localparam int HW   = $clog2(GRID_H + 1);
    localparam int CNTW = $clog2(FALL_DIV);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(FALL_DIV - 1);
`ifdef PIECE_FALL_CTL_HARD_DROP_EN
    localparam logic [4:0] LOCK_PTS = 5'd2;
`else
    localparam logic [4:0] LOCK_PTS = 5'd1;
`endif

    typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_FALL, S_LOCK, S_CLEAR, S_OVER} state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   h_q [GRID_W];
    logic [HW-1:0]   h_d [GRID_W];
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [11:0]     xpos_q, xpos_d, ypos_q, ypos_d;
    logic [15:0]     score_q, score_d;
    logic            game_over_q, game_over_d;
    logic [3:0]      btn_prev_q;
`ifdef PIECE_FALL_CTL_HARD_DROP_EN
    logic            drop_q, drop_d;
`endif

    logic [3:0]    btn_lvl, btn_edge;
    logic [CW-1:0] left_idx, right_idx;
    logic          can_left, can_right, can_down, all_full, pos_we, do_down;

    // Bit order: {rotate, down, right, left}.
    assign btn_lvl  = {button_rotate, button_down, button_right, button_left};
    assign btn_edge = btn_lvl & ~btn_prev_q;

    // Neighbour indices are clamped so the stack read stays in range at the walls.
    assign left_idx  = (col_q == '0) ? col_q : col_q - 1'b1;
    assign right_idx = (int'(col_q) >= GRID_W - 1) ? col_q : col_q + 1'b1;
    assign can_left  = (col_q != '0) && (int'(row_q) < GRID_H - int'(h_q[left_idx]));
    assign can_right = (int'(col_q) < GRID_W - 1) && (int'(row_q) < GRID_H - int'(h_q[right_idx]));
    assign can_down  = int'(row_q) < GRID_H - 1 - int'(h_q[col_q]);

    always_comb begin
        all_full = 1'b1;
        for (int c = 0; c < GRID_W; c++) begin
            if (h_q[c] == '0) all_full = 1'b0;
        end
    end

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        col_d       = col_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        score_d     = score_q;
        game_over_d = game_over_q;
        pos_we      = 1'b0;
        do_down     = 1'b0;
`ifdef PIECE_FALL_CTL_HARD_DROP_EN
        drop_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_OVER: begin
                if (btn_edge[3]) begin
                    for (int c = 0; c < GRID_W; c++) h_d[c] = '0;
                    score_d     = '0;
                    game_over_d = 1'b0;
                    state_d     = S_SPAWN;
                end
            end
            S_SPAWN: begin
                col_d  = CW'(GRID_W / 2);
                row_d  = '0;
                cnt_d  = '0;
                pos_we = 1'b1;
                if (h_q[GRID_W / 2] >= HW'(GRID_H)) begin
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else begin
                    state_d = S_FALL;
                end
            end
            S_FALL: begin
`ifdef PIECE_FALL_CTL_HARD_DROP_EN
                if (drop_q) begin
                    state_d = S_LOCK;
                end else
`endif
                if (btn_edge[0] || btn_edge[1]) begin
                    // A sideways request owns the cycle; a due tick waits at the top count.
                    if (btn_edge[0]) begin
                        if (can_left) begin
                            col_d  = col_q - 1'b1;
                            pos_we = 1'b1;
                        end
                    end else if (can_right) begin
                        col_d  = col_q + 1'b1;
                        pos_we = 1'b1;
                    end
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end else if (btn_edge[2]) begin
`ifdef PIECE_FALL_CTL_HARD_DROP_EN
                    row_d  = RW'(GRID_H - 1 - int'(h_q[col_q]));
                    cnt_d  = '0;
                    pos_we = 1'b1;
                    drop_d = 1'b1;
`else
                    do_down = 1'b1;
`endif
                end else if (cnt_q == CNT_MAX) begin
                    do_down = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (do_down) begin
                    if (can_down) begin
                        row_d  = row_q + 1'b1;
                        cnt_d  = '0;
                        pos_we = 1'b1;
                    end else begin
                        state_d = S_LOCK;
                    end
                end
            end
            S_LOCK: begin
                h_d[col_q] = h_q[col_q] + 1'b1;
                score_d    = sat_add(score_q, LOCK_PTS);
                state_d    = S_CLEAR;
            end
            S_CLEAR: begin
                if (all_full) begin
                    for (int c = 0; c < GRID_W; c++) h_d[c] = h_q[c] - 1'b1;
                    score_d = sat_add(score_q, 5'd10);
                end
                state_d = S_SPAWN;
            end
            default: state_d = S_IDLE;
        endcase

        xpos_d = xpos_q;
        ypos_d = ypos_q;
        if (pos_we) begin
            xpos_d = 12'(X0 + int'(col_d) * CELL);
            ypos_d = 12'(Y0 + int'(row_d) * CELL);
        end
    end

    // NOTE: the stack-height array is reset along with the rest, since a reset mid-game must leave an empty board.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int c = 0; c < GRID_W; c++) h_q[c] <= '0;
            col_q       <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            xpos_q      <= '0;
            ypos_q      <= '0;
            score_q     <= '0;
            game_over_q <= 1'b0;
            btn_prev_q  <= '0;
`ifdef PIECE_FALL_CTL_HARD_DROP_EN
            drop_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
            btn_prev_q  <= btn_lvl;
`ifdef PIECE_FALL_CTL_HARD_DROP_EN
            drop_q      <= drop_d;
`endif
        end
    end

    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign active      = (state_q == S_FALL);
    assign lock_pulse  = (state_q == S_LOCK);
    assign clear_pulse = (state_q == S_CLEAR) && all_full;
    assign score       = score_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_piece_fall_ctl.sv
// Directed scoreboard bench for piece_fall_ctl (FALL_DIV=16, default board geometry).
module tb_piece_fall_ctl;

    localparam int FALL_DIV = 16;
`ifdef PIECE_FALL_CTL_HARD_DROP_EN
    localparam int LOCK_PTS = 2;
`else
    localparam int LOCK_PTS = 1;
`endif

    logic        pclk = 1'b0;
    logic        rst;
    logic        button_left, button_right, button_down, button_rotate;
    logic [11:0] xpos, ypos;
    logic        active, lock_pulse, clear_pulse, game_over;
    logic [15:0] score;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_score = 0;

    piece_fall_ctl #(.FALL_DIV(FALL_DIV)) dut (
        .pclk         (pclk),
        .rst          (rst),
        .button_left  (button_left),
        .button_right (button_right),
        .button_down  (button_down),
        .button_rotate(button_rotate),
        .xpos         (xpos),
        .ypos         (ypos),
        .active       (active),
        .lock_pulse   (lock_pulse),
        .clear_pulse  (clear_pulse),
        .score        (score),
        .game_over    (game_over)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %0d expected none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val)
            else begin
                n_bad++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic press_left(input int n);
        repeat (n) begin
            button_left = 1'b1; step(1);
            button_left = 1'b0; step(1);
        end
    endtask

    task automatic press_right(input int n);
        repeat (n) begin
            button_right = 1'b1; step(1);
            button_right = 1'b0; step(1);
        end
    endtask

    task automatic wait_active();
        for (int i = 0; i < 20 && !active; i++) step(1);
        expect_val("wait_active", 1);
        check(active);
    endtask

    // Pulses down until the piece locks; returns with the bench sampling the LOCK cycle.
    task automatic drop_piece(output logic [11:0] land_y);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            button_down = 1'b1; step(1);
            if (lock_pulse) seen = 1'b1;
            else begin
                button_down = 1'b0; step(1);
                if (lock_pulse) seen = 1'b1;
            end
        end
        button_down = 1'b0;
        land_y = ypos;
        expect_val("lock_seen", 1);
        check(seen);
        exp_score += LOCK_PTS;
    endtask

    task automatic place(input int col, input int land);
        logic [11:0] y;
        wait_active();
        if (col < 5) press_left(5 - col);
        else press_right(col - 5);
        drop_piece(y);
        expect_val($sformatf("land_col%0d", col), land);
        check(y);
    endtask

    task automatic check_reset_outputs(input string pfx);
        expect_val({pfx, "_xpos"}, 0);        check(xpos);
        expect_val({pfx, "_ypos"}, 0);        check(ypos);
        expect_val({pfx, "_active"}, 0);      check(active);
        expect_val({pfx, "_lock"}, 0);        check(lock_pulse);
        expect_val({pfx, "_clear"}, 0);       check(clear_pulse);
        expect_val({pfx, "_score"}, 0);       check(score);
        expect_val({pfx, "_game_over"}, 0);   check(game_over);
    endtask

    initial begin
        logic [11:0] y;

        rst = 1'b1;
        button_left = 1'b0; button_right = 1'b0; button_down = 1'b0; button_rotate = 1'b0;
        step(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        step(1);

        // Idle ignores moves.
        press_left(1);
        expect_val("idle_active", 0); check(active);

        // Start game.
        button_rotate = 1'b1; step(1);
        button_rotate = 1'b0; step(1);
        expect_val("start_active", 1); check(active);
        expect_val("start_xpos", 275); check(xpos);
        expect_val("start_ypos", 20);  check(ypos);
        expect_val("start_score", 0);  check(score);

        // Gravity from spawn on empty board.
        step(15);
        expect_val("grav_before_tick", 20); check(ypos);
        step(1);
        expect_val("grav_first_tick", 55);  check(ypos);
        step(288);
        expect_val("grav_row19", 685);      check(ypos);
        step(15);
        expect_val("grav_no_lock_yet", 0);  check(lock_pulse);
        step(1);
        expect_val("grav_lock_pulse", 1);   check(lock_pulse);
        expect_val("grav_score_in_lock", 0); check(score);
        exp_score += LOCK_PTS;
        step(1);
        expect_val("grav_score_after", exp_score); check(score);
        expect_val("grav_lock_done", 0);    check(lock_pulse);
        expect_val("grav_no_clear", 0);     check(clear_pulse);
        step(2);
        expect_val("respawn_active", 1);    check(active);
        expect_val("respawn_ypos", 20);     check(ypos);

        // Six lefts from column 5 stop at column 0; right moves back one.
        press_left(6);
        expect_val("left_wall_xpos", 100);  check(xpos);
        expect_val("left_wall_ypos", 20);   check(ypos);
        press_right(1);
        expect_val("right_xpos", 135);      check(xpos);

        // Tick due while a left edge arrives: the move wins, the tick fires a cycle later.
        step(1);
        button_left = 1'b1; step(1);
        expect_val("held_tick_xpos", 100);  check(xpos);
        expect_val("held_tick_ypos", 20);   check(ypos);
        button_left = 1'b0; step(1);
        expect_val("held_tick_fired", 55);  check(ypos);

        drop_piece(y);
        expect_val("land_col0", 685); check(y);
        step(1);
        expect_val("score_col0", exp_score); check(score);

        // Fill the remaining columns; the tenth lock clears the row.
        for (int c = 1; c < 9; c++) begin
            if (c == 5) continue;
            place(c, 685);
            step(1);
            expect_val($sformatf("score_col%0d", c), exp_score); check(score);
        end
        place(9, 685);
        expect_val("tenth_no_clear_yet", 0); check(clear_pulse);
        step(1);
        expect_val("tenth_clear_pulse", 1);  check(clear_pulse);
        expect_val("tenth_lock_gone", 0);    check(lock_pulse);
        expect_val("tenth_score_pre", exp_score); check(score);
        exp_score += 10;
        step(1);
        expect_val("clear_score", exp_score); check(score);
        expect_val("clear_pulse_gone", 0);    check(clear_pulse);

        // Stack column 5 to the top; landing rows prove the clear emptied it.
        for (int k = 0; k < 20; k++) begin
            wait_active();
            drop_piece(y);
            expect_val($sformatf("stack_land%0d", k), 20 + (19 - k) * 35);
            check(y);
        end
        for (int i = 0; i < 10 && !game_over; i++) step(1);
        expect_val("over_flag", 1);       check(game_over);
        expect_val("over_active", 0);     check(active);
        expect_val("over_score", exp_score); check(score);
        press_left(1);
        expect_val("over_ignores_left", 0); check(active);

        // Restart from game over.
        button_rotate = 1'b1; step(1);
        expect_val("restart_score", 0);     check(score);
        expect_val("restart_game_over", 0); check(game_over);
        button_rotate = 1'b0; step(1);
        exp_score = 0;
        expect_val("restart_active", 1);    check(active);
        expect_val("restart_xpos", 275);    check(xpos);

`ifdef PIECE_FALL_CTL_HARD_DROP_EN
        button_down = 1'b1; step(1);
        expect_val("hard_drop_ypos", 685);  check(ypos);
        expect_val("hard_drop_no_lock", 0); check(lock_pulse);
        button_down = 1'b0; step(1);
        expect_val("hard_drop_lock", 1);    check(lock_pulse);
        exp_score += LOCK_PTS;
        step(1);
        expect_val("hard_drop_score", 2);   check(score);
        wait_active();
        drop_piece(y);
        expect_val("hard_drop_land2", 650); check(y);
`else
        button_down = 1'b1; step(1);
        expect_val("soft_drop_ypos", 55);   check(ypos);
        button_down = 1'b0; step(1);
        drop_piece(y);
        expect_val("soft_drop_land", 685);  check(y);
`endif
        // Reset in the middle of LOCK.
        expect_val("pre_reset_lock", 1);    check(lock_pulse);
        rst = 1'b1; step(1);
        check_reset_outputs("lock_reset");
        rst = 1'b0; step(2);
        expect_val("post_reset_idle", 0);   check(active);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/piece_fall_ctl.md
PIECE_FALL_CTL -- requirements
Module: piece_fall_ctl

Interface
REQ-001 SHALL have parameter GRID_W, default 10, board width in columns (4..16).
REQ-002 SHALL have parameter GRID_H, default 20, board height in rows (4..31).
REQ-003 SHALL have parameter CELL, default 35, cell pitch in pixels.
REQ-004 SHALL have parameters X0 and Y0, defaults 100 and 20, pixel origin of cell (0,0).
REQ-005 SHALL have parameter FALL_DIV, default 1048576, gravity period in clocks (>=2).
REQ-006 SHALL have port pclk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports button_left, button_right, button_down, input, 1 each, level move requests.
REQ-009 SHALL have port button_rotate, input, 1, start/restart request (a 1x1 piece has no rotation).
REQ-010 SHALL have ports xpos and ypos, output, 12 each, registered pixel position of the active piece.
REQ-011 SHALL have port active, output, 1, high while a piece is falling (FALL).
REQ-012 SHALL have ports lock_pulse and clear_pulse, output, 1 each, single-cycle event strobes.
REQ-013 SHALL have ports score, output, 16, and game_over, output, 1.

Function
REQ-014 SHALL act only on rising edges of each button: edge = level AND NOT previous level, previous-level registers reset to 0.
REQ-015 SHALL keep per-column stack heights h[c] (0..GRID_H); row 0 is top, row GRID_H-1 is bottom; piece cell is (col,row).
REQ-016 SHALL implement states IDLE, SPAWN, FALL, LOCK, CLEAR, OVER.
REQ-017 IDLE/OVER: on button_rotate edge, clear every h[c], score and game_over, then go to SPAWN; otherwise hold.
REQ-018 SPAWN: col=GRID_W/2, row=0, gravity counter=0; go to OVER with game_over=1 if h[col]>=GRID_H, else go to FALL.
REQ-019 FALL: at most one action per cycle, priority left > right > down edge > gravity tick.
REQ-020 Left succeeds only if col>0 and row < GRID_H-h[col-1]; right only if col<GRID_W-1 and row < GRID_H-h[col+1]; blocked moves are ignored.
REQ-021 A down attempt (button or tick) succeeds if row < GRID_H-1-h[col]: row increments and the gravity counter restarts at 0.
REQ-022 A failed down attempt SHALL go to LOCK.
REQ-023 Gravity counter SHALL count 0..FALL_DIV-1 in FALL; the tick fires at FALL_DIV-1; a tick suppressed by a left/right action SHALL hold the counter at FALL_DIV-1 and fire next cycle.
REQ-024 LOCK (one cycle): h[col]++, lock_pulse=1, score+=1; next state CLEAR.
REQ-025 CLEAR (one cycle): if every h[c]>=1, decrement all h[c], clear_pulse=1, score+=10; next state SPAWN.
REQ-026 Score SHALL saturate at 16'hFFFF, never wrap.
REQ-027 xpos=X0+col*CELL, ypos=Y0+row*CELL, truncated to 12 bits, updated on the same edge as col/row.
REQ-028 Inputs in SPAWN, LOCK, CLEAR SHALL be ignored (edges consumed, not queued).

Reset
REQ-029 On rst: state IDLE, all h[c]=0, col=0, row=0, counter=0, xpos=0, ypos=0, active=0, lock_pulse=0, clear_pulse=0, score=0, game_over=0.
REQ-030 Reset SHALL take precedence over any state, including mid-LOCK or mid-CLEAR, and no partial update SHALL survive.

Configuration
REQ-031 Macro PIECE_FALL_CTL_HARD_DROP_EN defined: a button_down edge in FALL moves row directly to GRID_H-1-h[col] and enters LOCK on the following cycle, adding 2 (not 1) to score in LOCK.
REQ-032 Macro PIECE_FALL_CTL_HARD_DROP_EN undefined: a button_down edge is a one-row soft drop per REQ-021, and lock adds 1.

Verification (defaults, FALL_DIV=16)
REQ-033 Reset, then button_rotate pulse -> SPAWN then FALL; xpos=275, ypos=20, active=1, score=0.
REQ-034 No buttons from spawn on empty board -> ypos +35 every 16 clocks to 685 (row 19); next tick gives lock_pulse, score=1, h[5]=1, respawn at ypos=20.
REQ-035 Six button_left edges from spawn -> col stops at 0, xpos=100; extra edge ignored; button_right then xpos=135.
REQ-036 Fill columns 0..9 to h=1 via ten locks -> tenth lock gives lock_pulse then clear_pulse next cycle, all h=0, score=20.
REQ-037 Stack column 5 to h=20 -> next SPAWN asserts game_over=1, active=0; button_rotate edge restarts with score=0.
REQ-038 Hard-drop build, down edge at spawn on empty board -> ypos=685 next cycle, lock_pulse the cycle after, score=2; rst asserted during LOCK -> all outputs at reset values.
